// File: rtl/rtr_next_hop_addr_vc_tracker.sv
// Registered per-VC next-hop address tracker for lookahead routing (LINE / RING / FULL, phased DOR).
// Optional sticky protocol/hop checking is enabled by defining RTR_NHA_ERR_CHECK_EN.
`ifndef CONNECTIVITY_LINE
`define CONNECTIVITY_LINE 0
`endif
`ifndef CONNECTIVITY_RING
`define CONNECTIVITY_RING 1
`endif
`ifndef CONNECTIVITY_FULL
`define CONNECTIVITY_FULL 2
`endif
`ifndef ROUTING_TYPE_PHASED_DOR
`define ROUTING_TYPE_PHASED_DOR 0
`endif

module rtr_next_hop_addr_vc_tracker #(
   parameter int num_vcs              = 4,
   parameter int num_resource_classes = 2,
   parameter int num_routers_per_dim  = 4,
   parameter int num_dimensions       = 2,
   parameter int num_nodes_per_router = 1,
   parameter int connectivity         = `CONNECTIVITY_LINE,
   parameter int routing_type         = `ROUTING_TYPE_PHASED_DOR,
   localparam int dim_addr_width        = $clog2(num_routers_per_dim),
   localparam int router_addr_width     = num_dimensions * dim_addr_width,
   localparam int num_neighbors_per_dim = (connectivity == `CONNECTIVITY_FULL) ?
                                          (num_routers_per_dim - 1) : 2,
   localparam int num_ports             = num_dimensions * num_neighbors_per_dim +
                                          num_nodes_per_router,
   localparam int port_idx_width        = $clog2(num_ports),
   localparam int rc_sel_width          = $clog2(num_resource_classes),
   localparam int lar_info_width        = port_idx_width + rc_sel_width,
   localparam int dest_info_width       = num_resource_classes * router_addr_width +
                                          $clog2(num_nodes_per_router)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [router_addr_width-1:0] router_address,
   input  logic                         flit_valid_in,
   input  logic                         flit_head_in,
   input  logic                         flit_tail_in,
   input  logic [num_vcs-1:0]           flit_sel_in_ivc,
   input  logic [dest_info_width-1:0]   dest_info_in,
   input  logic [lar_info_width-1:0]    lar_info_in,
   output logic                         next_addr_valid_out,
   output logic [num_vcs-1:0]           next_addr_vc_out,
   output logic [router_addr_width-1:0] next_router_address_out,
   output logic [num_vcs-1:0]           vc_active_ivc,
   output logic                         error_out
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   if (routing_type != `ROUTING_TYPE_PHASED_DOR) begin : g_bad_routing
      $error("rtr_next_hop_addr_vc_tracker supports only phased DOR routing");
   end

   logic [port_idx_width-1:0]    route_port;
   int                           port_i;
   int                           rc_sel_i;
   logic [router_addr_width-1:0] dest_addr;
   logic [router_addr_width-1:0] hop_addr;
   logic                         hop_err;
   logic [dim_addr_width-1:0]    cur;
   logic [dim_addr_width-1:0]    nxt;
   logic [router_addr_width-1:0] slot_rd;

   logic [0:0]                   state_q [num_vcs];
   logic [0:0]                   state_d [num_vcs];
   logic [router_addr_width-1:0] slot_q  [num_vcs];
   logic [router_addr_width-1:0] slot_d  [num_vcs];
   logic                         valid_q, valid_d;
   logic [num_vcs-1:0]           vc_q, vc_d;
   logic [router_addr_width-1:0] addr_q, addr_d;

   assign route_port = lar_info_in[lar_info_width-1 -: port_idx_width];
   assign port_i     = int'(route_port);

   if (rc_sel_width > 0) begin : g_rc_sel
      assign rc_sel_i = int'(lar_info_in[rc_sel_width-1:0]);
   end else begin : g_no_rc_sel
      assign rc_sel_i = 0;
   end

   always_comb begin
      dest_addr = dest_info_in[router_addr_width-1:0];
      for (int r = 0; r < num_resource_classes; r++) begin
         if (rc_sel_i == r) dest_addr = dest_info_in[r*router_addr_width +: router_addr_width];
      end
   end

   // Per-dimension hop; LINE deliberately wraps modulo the field width (the checker flags it).
   always_comb begin
      hop_addr = router_address;
      hop_err  = 1'b0;
      cur      = '0;
      nxt      = '0;
      for (int d = 0; d < num_dimensions; d++) begin
         cur = router_address[d*dim_addr_width +: dim_addr_width];
         nxt = cur;
         if (connectivity == `CONNECTIVITY_FULL) begin
            if (port_i >= d*num_neighbors_per_dim && port_i < (d+1)*num_neighbors_per_dim)
               nxt = dest_addr[d*dim_addr_width +: dim_addr_width];
         end else if (port_i == 2*d) begin
            if (connectivity == `CONNECTIVITY_RING && cur == '0)
               nxt = dim_addr_width'(num_routers_per_dim - 1);
            else
               nxt = cur - 1'b1;
            if (connectivity == `CONNECTIVITY_LINE && cur == '0) hop_err = 1'b1;
         end else if (port_i == 2*d + 1) begin
            if (connectivity == `CONNECTIVITY_RING &&
                cur == dim_addr_width'(num_routers_per_dim - 1))
               nxt = '0;
            else
               nxt = cur + 1'b1;
            if (connectivity == `CONNECTIVITY_LINE &&
                cur == dim_addr_width'(num_routers_per_dim - 1)) hop_err = 1'b1;
         end
         hop_addr[d*dim_addr_width +: dim_addr_width] = nxt;
      end
      if (port_i >= num_dimensions*num_neighbors_per_dim) begin
         hop_addr = router_address;
         hop_err  = 1'b0;
      end
   end

   always_comb begin
      slot_rd = '0;
      for (int v = 0; v < num_vcs; v++) begin
         state_d[v] = state_q[v];
         slot_d[v]  = slot_q[v];
         if (flit_sel_in_ivc[v]) slot_rd = slot_rd | slot_q[v];
         if (flit_valid_in && flit_sel_in_ivc[v]) begin
            if (flit_tail_in)      state_d[v] = ST_IDLE;
            else if (flit_head_in) state_d[v] = ST_ACTIVE;
            if (flit_head_in)      slot_d[v]  = hop_addr;
         end
      end
   end

   always_comb begin
      valid_d = flit_valid_in;
      vc_d    = vc_q;
      addr_d  = addr_q;
      if (flit_valid_in) begin
         vc_d   = flit_sel_in_ivc;
         addr_d = flit_head_in ? hop_addr : slot_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int v = 0; v < num_vcs; v++) begin
            state_q[v] <= ST_IDLE;
            slot_q[v]  <= '0;
         end
         valid_q <= 1'b0;
         vc_q    <= '0;
         addr_q  <= '0;
      end else begin
         for (int v = 0; v < num_vcs; v++) begin
            state_q[v] <= state_d[v];
            slot_q[v]  <= slot_d[v];
         end
         valid_q <= valid_d;
         vc_q    <= vc_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      for (int v = 0; v < num_vcs; v++) vc_active_ivc[v] = (state_q[v] == ST_ACTIVE);
   end

   assign next_addr_valid_out     = valid_q;
   assign next_addr_vc_out        = vc_q;
   assign next_router_address_out = addr_q;

`ifdef RTR_NHA_ERR_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (flit_valid_in) begin
         if (flit_sel_in_ivc == '0 || (flit_sel_in_ivc & (flit_sel_in_ivc - 1'b1)) != '0)
            err_d = 1'b1;
         for (int v = 0; v < num_vcs; v++) begin
            if (flit_sel_in_ivc[v]) begin
               if (flit_head_in && state_q[v] == ST_ACTIVE) err_d = 1'b1;
               if (!flit_head_in && state_q[v] == ST_IDLE)  err_d = 1'b1;
            end
         end
         if (flit_head_in && (hop_err || port_i >= num_ports)) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   assign error_out = err_q;
`else
   assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_rtr_next_hop_addr_vc_tracker.sv
// Bench for rtr_next_hop_addr_vc_tracker: LINE, RING and FULL instances against a coordinate-level model.
// Addresses are written (dim0,dim1); dim0 occupies the low field, so (x,y) = x + 4*y.
`ifndef CONNECTIVITY_LINE
`define CONNECTIVITY_LINE 0
`endif
`ifndef CONNECTIVITY_RING
`define CONNECTIVITY_RING 1
`endif
`ifndef CONNECTIVITY_FULL
`define CONNECTIVITY_FULL 2
`endif

module tb_rtr_next_hop_addr_vc_tracker;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       fv [3];
   logic       fh [3];
   logic       ft [3];
   logic [3:0] sel [3];
   logic [7:0] dinfo [3];
   logic [3:0] lar [3];
   logic [3:0] raddr [3];
   logic       ov [3];
   logic [3:0] ovc [3];
   logic [3:0] oaddr [3];
   logic [3:0] oact [3];
   logic       oerr [3];

   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 0;

   // Model state: packet-in-progress flag and stored address per instance/VC, plus expected outputs
   bit m_pkt [3][4];
   int m_slot [3][4];
   int e_valid [3];
   int e_vc [3];
   int e_addr [3];
   int e_err [3];

   always #5 clk = ~clk;

   rtr_next_hop_addr_vc_tracker #(.connectivity(`CONNECTIVITY_LINE)) u_line (
      .clk(clk), .reset_n(reset_n), .router_address(raddr[0]),
      .flit_valid_in(fv[0]), .flit_head_in(fh[0]), .flit_tail_in(ft[0]),
      .flit_sel_in_ivc(sel[0]), .dest_info_in(dinfo[0]), .lar_info_in(lar[0]),
      .next_addr_valid_out(ov[0]), .next_addr_vc_out(ovc[0]),
      .next_router_address_out(oaddr[0]), .vc_active_ivc(oact[0]), .error_out(oerr[0]));

   rtr_next_hop_addr_vc_tracker #(.connectivity(`CONNECTIVITY_RING)) u_ring (
      .clk(clk), .reset_n(reset_n), .router_address(raddr[1]),
      .flit_valid_in(fv[1]), .flit_head_in(fh[1]), .flit_tail_in(ft[1]),
      .flit_sel_in_ivc(sel[1]), .dest_info_in(dinfo[1]), .lar_info_in(lar[1]),
      .next_addr_valid_out(ov[1]), .next_addr_vc_out(ovc[1]),
      .next_router_address_out(oaddr[1]), .vc_active_ivc(oact[1]), .error_out(oerr[1]));

   rtr_next_hop_addr_vc_tracker #(.connectivity(`CONNECTIVITY_FULL)) u_full (
      .clk(clk), .reset_n(reset_n), .router_address(raddr[2]),
      .flit_valid_in(fv[2]), .flit_head_in(fh[2]), .flit_tail_in(ft[2]),
      .flit_sel_in_ivc(sel[2]), .dest_info_in(dinfo[2]), .lar_info_in(lar[2]),
      .next_addr_valid_out(ov[2]), .next_addr_vc_out(ovc[2]),
      .next_router_address_out(oaddr[2]), .vc_active_ivc(oact[2]), .error_out(oerr[2]));

   // Next hop in coordinate terms; instance 2 is FULL (3 neighbours per dim), others have 2
   function automatic int nextHop(int inst, int ra, int port, int di, int rc);
      int nb;
      int c [2];
      int dest;
      int d;
      nb = (inst == 2) ? 3 : 2;
      if (port >= 2*nb) return ra;
      c[0] = ra % 4;
      c[1] = ra / 4;
      dest = (di >> (4*rc)) % 16;
      d    = port / nb;
      if (inst == 2)            c[d] = (d == 0) ? dest % 4 : dest / 4;
      else if (port % nb == 0)  c[d] = (c[d] + 3) % 4;
      else                      c[d] = (c[d] + 1) % 4;
      return c[0] + 4*c[1];
   endfunction

   task automatic checkOutput(string name, int inst, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s inst%0d actual=%0d required=%0d at %0t", name, inst, act, exp, $time);
      end
   endtask

   // Advance the model on every clock edge using the same inputs the DUTs sample
   always @(posedge clk) begin
      int v, port, rc, addr, coord;
      for (int i = 0; i < 3; i++) begin
         if (!reset_n) begin
            e_valid[i] = 0; e_vc[i] = 0; e_addr[i] = 0; e_err[i] = 0;
            for (int k = 0; k < 4; k++) begin m_pkt[i][k] = 0; m_slot[i][k] = 0; end
         end else if (fv[i]) begin
            v = 0;
            for (int k = 0; k < 4; k++) if (sel[i][k]) v = k;
            port = int'(lar[i]) / 2;
            rc   = int'(lar[i]) % 2;
`ifdef RTR_NHA_ERR_CHECK_EN
            if ($countones(sel[i]) != 1) e_err[i] = 1;
            if (fh[i] && m_pkt[i][v])    e_err[i] = 1;
            if (!fh[i] && !m_pkt[i][v])  e_err[i] = 1;
            if (fh[i] && port >= ((i == 2) ? 7 : 5)) e_err[i] = 1;
            if (fh[i] && i == 0 && port < 4) begin
               coord = (port / 2 == 0) ? int'(raddr[i]) % 4 : int'(raddr[i]) / 4;
               if ((port % 2 == 0 && coord == 0) || (port % 2 == 1 && coord == 3)) e_err[i] = 1;
            end
`endif
            if (fh[i]) begin
               addr = nextHop(i, int'(raddr[i]), port, int'(dinfo[i]), rc);
               m_slot[i][v] = addr;
            end else begin
               addr = m_slot[i][v];
            end
            if (ft[i])      m_pkt[i][v] = 0;
            else if (fh[i]) m_pkt[i][v] = 1;
            e_valid[i] = 1;
            e_vc[i]    = int'(sel[i]);
            e_addr[i]  = addr;
         end else begin
            e_valid[i] = 0;
         end
      end
   end

   // Every falling edge, every instance's outputs are compared against the model
   always @(negedge clk) begin
      int act;
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            act = 0;
            for (int k = 0; k < 4; k++) if (m_pkt[i][k]) act = act | (1 << k);
            checkOutput("valid", i, int'(ov[i]), e_valid[i]);
            checkOutput("vc", i, int'(ovc[i]), e_vc[i]);
            checkOutput("addr", i, int'(oaddr[i]), e_addr[i]);
            checkOutput("active", i, int'(oact[i]), act);
            checkOutput("error", i, int'(oerr[i]), e_err[i]);
         end
      end
   end

   // Drive one flit on one instance for a single cycle; returns at the next falling edge
   task automatic applyStimulus(int inst, bit h, bit t, int vc, int port, int rc, int di);
      fv[inst]    = 1'b1;
      fh[inst]    = h;
      ft[inst]    = t;
      sel[inst]   = 4'(1 << vc);
      lar[inst]   = 4'(port*2 + rc);
      dinfo[inst] = 8'(di);
      @(negedge clk);
      fv[inst] = 1'b0;
      fh[inst] = 1'b0;
      ft[inst] = 1'b0;
   endtask

   // Hand-computed expectation for the flit just applied
   task automatic expectLiteral(string name, int inst, int vc, int addr, int active);
      checkOutput({name, "_valid"}, inst, int'(ov[inst]), 1);
      checkOutput({name, "_vc"}, inst, int'(ovc[inst]), 1 << vc);
      checkOutput({name, "_addr"}, inst, int'(oaddr[inst]), addr);
      checkOutput({name, "_active"}, inst, int'(oact[inst]), active);
   endtask

   task automatic doReset(int n);
      reset_n = 1'b0;
      repeat (n) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         fv[i] = 0; fh[i] = 0; ft[i] = 0; sel[i] = '0; dinfo[i] = '0; lar[i] = '0; raddr[i] = '0;
      end
      @(negedge clk);
      chk_en = 1;
      doReset(2);
      for (int i = 0; i < 3; i++) begin
         checkOutput("rst_valid", i, int'(ov[i]), 0);
         checkOutput("rst_addr", i, int'(oaddr[i]), 0);
         checkOutput("rst_active", i, int'(oact[i]), 0);
         checkOutput("rst_error", i, int'(oerr[i]), 0);
      end

      // LINE at (1,2): dim1-up head, body, tail all carry (1,3); then a dim0-up single flit -> (2,2)
      raddr[0] = 4'd9;
      raddr[1] = 4'd3;
      raddr[2] = 4'd12;
      applyStimulus(0, 1, 0, 0, 3, 0, 0);
      expectLiteral("line_head", 0, 0, 13, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      expectLiteral("line_body", 0, 0, 13, 1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      expectLiteral("line_tail", 0, 0, 13, 0);
      applyStimulus(0, 1, 1, 1, 1, 0, 0);
      expectLiteral("line_single", 0, 1, 10, 0);

      // RING at (3,0): wrap up in dim0, wrap down in dim1, eject keeps own address
      applyStimulus(1, 1, 1, 0, 1, 0, 0);
      expectLiteral("ring_p1", 1, 0, 0, 0);
      applyStimulus(1, 1, 1, 0, 2, 0, 0);
      expectLiteral("ring_p2", 1, 0, 15, 0);
      applyStimulus(1, 1, 1, 0, 4, 0, 0);
      expectLiteral("ring_eject", 1, 0, 3, 0);

      // FULL at (0,3): class 1 destination (2,1), dim1 port 4 -> (0,1)
      applyStimulus(2, 1, 1, 3, 4, 1, 8'h65);
      expectLiteral("full_p4", 2, 3, 4, 0);

      // Interleaved packets on LINE: VC0 port0 -> (0,2), VC1 port3 -> (1,3)
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      expectLiteral("il_h0", 0, 0, 8, 1);
      applyStimulus(0, 1, 0, 1, 3, 0, 0);
      expectLiteral("il_h1", 0, 1, 13, 3);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      expectLiteral("il_b0", 0, 0, 8, 3);
      applyStimulus(0, 0, 1, 1, 0, 0, 0);
      expectLiteral("il_t1", 0, 1, 13, 1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      expectLiteral("il_t0", 0, 0, 8, 0);
      repeat (2) @(negedge clk);
      checkOutput("hold_addr", 0, int'(oaddr[0]), 8);

      // Reset while VC2 is mid-packet drops the pending body and clears slots
      applyStimulus(0, 1, 0, 2, 1, 0, 0);
      expectLiteral("mid_head", 0, 2, 10, 4);
      fv[0] = 1'b1; fh[0] = 1'b0; ft[0] = 1'b0; sel[0] = 4'b0100;
      reset_n = 1'b0;
      @(negedge clk);
      fv[0] = 1'b0;
      reset_n = 1'b1;
      checkOutput("mid_rst_valid", 0, int'(ov[0]), 0);
      checkOutput("mid_rst_active", 0, int'(oact[0]), 0);
      applyStimulus(0, 0, 0, 2, 0, 0, 0);
      expectLiteral("post_rst_body", 0, 2, 0, 0);
`ifdef RTR_NHA_ERR_CHECK_EN
      checkOutput("post_rst_err", 0, int'(oerr[0]), 1);
`else
      checkOutput("post_rst_err", 0, int'(oerr[0]), 0);
`endif

      // LINE at (0,0) heading down dim0 underflows to (3,0)
      doReset(1);
      raddr[0] = 4'd0;
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      expectLiteral("uflow", 0, 0, 3, 1);
      repeat (3) @(negedge clk);
`ifdef RTR_NHA_ERR_CHECK_EN
      checkOutput("uflow_err_sticky", 0, int'(oerr[0]), 1);
`else
      checkOutput("uflow_err_sticky", 0, int'(oerr[0]), 0);
`endif
      doReset(1);
      checkOutput("err_cleared", 0, int'(oerr[0]), 0);

      // Sweep every port field value on all topologies with varied addresses and destinations
      for (int i = 0; i < 3; i++) begin
         for (int p = 0; p < 8; p++) begin
            raddr[i] = 4'($urandom_range(0, 15));
            applyStimulus(i, 1, 1, p % 4, p, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
         end
      end
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
